gpio_cfg_loader: RTL

Serial configuration sequencer for the GPIO pad control chain. It takes a parallel image of every pad's configuration word from the register file and shifts it bit-serially into the daisy-chained pad control blocks. It then pulses the load strobe so all pads update together. It sits between the SoC register bank and the `serial_clock_in` / `serial_data_in` / `serial_load_in` inputs of the pad bank.

---
 rtl/gpio_cfg_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader: shifts a parallel pad-configuration image bit-serially
// into the daisy-chained GPIO pad control blocks, then strobes serial_load
// so every pad picks up its new word at the same time.
// Optional feature macro: GPIO_CFG_READBACK_EN (captures the previous chain
// contents from serial_data_ret into rb_data).
module gpio_cfg_loader #(
    parameter int NUM_PADS      = 6,
    parameter int PAD_CTRL_BITS = 12,
    parameter int CLK_DIV       = 4
) (
    input  logic                              mclk,
    input  logic                              reset,
    input  logic                              cfg_start,
    input  logic [NUM_PADS*PAD_CTRL_BITS-1:0] cfg_data,
    output logic                              cfg_busy,
    output logic                              cfg_done,
    output logic                              serial_clock,
    output logic                              serial_data,
    output logic                              serial_load
`ifdef GPIO_CFG_READBACK_EN
   ,input  logic                              serial_data_ret
   ,output logic [NUM_PADS*PAD_CTRL_BITS-1:0] rb_data
`endif
);

    localparam int B  = NUM_PADS * PAD_CTRL_BITS;
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int CW = $clog2(B);

    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(B - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PW-1:0]   r_phase;
    logic [CW-1:0]   r_bitcnt;
    logic [B-1:0]    r_shift;
    logic            r_busy;
    logic            r_done;
    logic            r_sclk;
    logic            r_load;
    logic            w_phase_end;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_sclk_nxt;
    logic            w_load_nxt;

    assign w_phase_end = (r_phase == PHASE_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the next values of the registered outputs.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:     if (cfg_start)   w_next_state = S_SHIFT_LO;
            S_SHIFT_LO: if (w_phase_end) w_next_state = S_SHIFT_HI;
            S_SHIFT_HI: if (w_phase_end) w_next_state = (r_bitcnt == '0) ? S_LOAD : S_SHIFT_LO;
            S_LOAD:     if (w_phase_end) w_next_state = S_DONE;
            S_DONE:                      w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase

        w_busy_nxt = (w_next_state != S_IDLE) && (w_next_state != S_DONE);
        w_done_nxt = (w_next_state == S_DONE);
        w_sclk_nxt = (w_next_state == S_SHIFT_HI);
        w_load_nxt = (w_next_state == S_LOAD);
    end

    // Phase counter: counts CLK_DIV mclk cycles within each timed state.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (r_state == S_IDLE || r_state == S_DONE || w_phase_end) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PW'(1);
        end
    end

    // Image shift register and remaining-bit counter; image captured on start
    // so later cfg_data changes cannot disturb a running sequence.
    // NOTE: the wide shift register is reset even though it is datapath,
    // because its MSB is serial_data and must read 0 out of reset.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (r_state == S_IDLE && cfg_start) begin
            r_shift  <= cfg_data;
            r_bitcnt <= BIT_LAST;
        end else if (r_state == S_SHIFT_HI && w_phase_end) begin
            r_shift <= {r_shift[B-2:0], 1'b0};
            if (r_bitcnt != '0) begin
                r_bitcnt <= r_bitcnt - CW'(1);
            end
        end
    end

    // Output flops, aligned with the state register so pad-facing lines never glitch.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sclk <= 1'b0;
            r_load <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_sclk <= w_sclk_nxt;
            r_load <= w_load_nxt;
        end
    end

    assign cfg_busy     = r_busy;
    assign cfg_done     = r_done;
    assign serial_clock = r_sclk;
    assign serial_data  = r_shift[B-1];
    assign serial_load  = r_load;

`ifdef GPIO_CFG_READBACK_EN
    logic [B-1:0] r_cap;
    logic [B-1:0] r_rb;

    // Capture the chain tail at the end of each high phase; after B bits the
    // first bit out (old bit B-1) has reached the MSB, matching cfg_data order.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_cap <= '0;
            r_rb  <= '0;
        end else begin
            if (r_state == S_SHIFT_HI && w_phase_end) begin
                r_cap <= {r_cap[B-2:0], serial_data_ret};
            end
            if (r_state == S_LOAD && w_next_state == S_DONE) begin
                r_rb <= r_cap;
            end
        end
    end

    assign rb_data = r_rb;
`endif

endmodule
